// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Stall and flush controller for the 5-stage MIPS pipeline. It works alongside
// the forwarding unit and covers the hazards that bypassing cannot resolve:
//   * load-use: the consumer in ID needs a value that is still being loaded
//   * branch operands compared in ID whose producer is still in EX, or is a
//     load still in MEM
//   * a multi-cycle mul/div occupying EX
// All stall and flush controls are decoded in the same cycle as their inputs.
// The only sequential state is the mul/div occupancy FSM, its down-counter
// and a saturating count of stalled cycles.
//
// Parameters
//   MULDIV_CYCLES  cycles a mul/div occupies EX (1..255)
//
// Ports
//   clk           pipeline clock, rising edge
//   rst           synchronous active-high reset
//   IDEXMemRead   EX instruction is a load
//   IDEXRt        load destination in EX
//   IDEXRegWrite  EX instruction writes a register
//   IDEXRd        resolved destination of the EX instruction
//   EXMEMMemRead  MEM instruction is a load
//   EXMEMRd       destination of the MEM instruction
//   IFIDRs        Rs of the ID instruction
//   IFIDRt        Rt of the ID instruction
//   IFIDUseRt     ID instruction reads Rt
//   IFIDBranch    ID instruction is a conditional branch
//   BranchTaken   ID branch comparator result
//   Jump          ID instruction is a jump
//   IDEXMulDiv    EX instruction is a mul/div
//   PCWrite       PC update enable
//   IFIDWrite     IF/ID update enable
//   IDEXBubble    zero the control fields written into ID/EX
//   IFIDFlush     replace IF/ID contents with a nop
//   EXHold        freeze ID/EX and the mul/div unit, bubble EX/MEM
//   StallCount    saturating count of cycles with PCWrite low
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IDEXMemRead,
  input  logic [4:0]  IDEXRt,
  input  logic        IDEXRegWrite,
  input  logic [4:0]  IDEXRd,
  input  logic        EXMEMMemRead,
  input  logic [4:0]  EXMEMRd,
  input  logic [4:0]  IFIDRs,
  input  logic [4:0]  IFIDRt,
  input  logic        IFIDUseRt,
  input  logic        IFIDBranch,
  input  logic        BranchTaken,
  input  logic        Jump,
  input  logic        IDEXMulDiv,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXBubble,
  output logic        IFIDFlush,
  output logic        EXHold,
  output logic [15:0] StallCount
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // The cycle in which the mul/div is first seen in EX is already a hold
  // cycle, so BUSY only needs to cover the remaining MULDIV_CYCLES-1 cycles.
  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 1);

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;

  logic muldiv_hold;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic data_stall;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable driven here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (IDEXMulDiv) begin
          state_n = BUSY;
          cnt_n   = CNT_INIT;
        end
      end
      BUSY: begin
        // cnt==0 is the release cycle: the op advances out of EX and a new
        // mul/div can only be accepted once back in IDLE.
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    muldiv_hold = ((state == IDLE) && IDEXMulDiv) ||
                  ((state == BUSY) && (cnt != 8'd0));

    // Register 0 is hard-wired, so a match on it is never a real dependency.
    load_use = IDEXMemRead && (IDEXRt != 5'd0) &&
               ((IDEXRt == IFIDRs) || (IFIDUseRt && (IDEXRt == IFIDRt)));

    // Branches compare in ID, ahead of the EX forwarding path: an ALU result
    // still in EX, or a load still in MEM, cannot reach the comparator yet.
    br_ex  = IFIDBranch && IDEXRegWrite && (IDEXRd != 5'd0) &&
             ((IDEXRd == IFIDRs) || (IDEXRd == IFIDRt));
    br_mem = IFIDBranch && EXMEMMemRead && (EXMEMRd != 5'd0) &&
             ((EXMEMRd == IFIDRs) || (EXMEMRd == IFIDRt));

    // A mul/div hold freezes ID/EX outright, so a bubble would destroy the
    // held instruction; data stalls only apply when EX is free.
    data_stall = !muldiv_hold && (load_use || br_ex || br_mem);

    EXHold     = muldiv_hold;
    PCWrite    = !(muldiv_hold || data_stall);
    IFIDWrite  = !(muldiv_hold || data_stall);
    IDEXBubble = data_stall;
    // Redirects are suppressed while stalled; the branch/jump is still in ID
    // and is re-evaluated once the stall releases.
    IFIDFlush  = !muldiv_hold && !data_stall &&
                 ((IFIDBranch && BranchTaken) || Jump);
  end

  // ---------------------------------------------------------------------------
  // Stall-cycle counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= 16'd0;
    end else if (!PCWrite && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit with MULDIV_CYCLES=4. Inputs change 1 time
// unit after the rising edge and outputs are sampled 1 time unit later, well
// away from the next edge. Expected values are worked out by hand below.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic        IDEXMemRead;
  logic [4:0]  IDEXRt;
  logic        IDEXRegWrite;
  logic [4:0]  IDEXRd;
  logic        EXMEMMemRead;
  logic [4:0]  EXMEMRd;
  logic [4:0]  IFIDRs;
  logic [4:0]  IFIDRt;
  logic        IFIDUseRt;
  logic        IFIDBranch;
  logic        BranchTaken;
  logic        Jump;
  logic        IDEXMulDiv;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IDEXBubble;
  logic        IFIDFlush;
  logic        EXHold;
  logic [15:0] StallCount;

  int vectors;
  int miscompares;

  hazard_unit #(.MULDIV_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .IDEXMemRead  (IDEXMemRead),
    .IDEXRt       (IDEXRt),
    .IDEXRegWrite (IDEXRegWrite),
    .IDEXRd       (IDEXRd),
    .EXMEMMemRead (EXMEMMemRead),
    .EXMEMRd      (EXMEMRd),
    .IFIDRs       (IFIDRs),
    .IFIDRt       (IFIDRt),
    .IFIDUseRt    (IFIDUseRt),
    .IFIDBranch   (IFIDBranch),
    .BranchTaken  (BranchTaken),
    .Jump         (Jump),
    .IDEXMulDiv   (IDEXMulDiv),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .IDEXBubble   (IDEXBubble),
    .IFIDFlush    (IFIDFlush),
    .EXHold       (EXHold),
    .StallCount   (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks all five control outputs; IFIDWrite always tracks PCWrite.
  task automatic check_ctl(input string tag, input logic pc, input logic bub,
                           input logic fl, input logic hold);
    check_bit({tag, ".PCWrite"},    PCWrite,    pc);
    check_bit({tag, ".IFIDWrite"},  IFIDWrite,  pc);
    check_bit({tag, ".IDEXBubble"}, IDEXBubble, bub);
    check_bit({tag, ".IFIDFlush"},  IFIDFlush,  fl);
    check_bit({tag, ".EXHold"},     EXHold,     hold);
  endtask

  task automatic clear_inputs();
    IDEXMemRead  = 1'b0;
    IDEXRt       = 5'd0;
    IDEXRegWrite = 1'b0;
    IDEXRd       = 5'd0;
    EXMEMMemRead = 1'b0;
    EXMEMRd      = 5'd0;
    IFIDRs       = 5'd0;
    IFIDRt       = 5'd0;
    IFIDUseRt    = 1'b0;
    IFIDBranch   = 1'b0;
    BranchTaken  = 1'b0;
    Jump         = 1'b0;
    IDEXMulDiv   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    clear_inputs();

    // ---------------- reset ----------------
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_ctl("reset", 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("reset.StallCount", StallCount, 16'd0);

    // ---------------- load-use ----------------
    IDEXMemRead = 1'b1; IDEXRt = 5'd5; IFIDRs = 5'd5;
    #1;
    check_ctl("loaduse", 1'b0, 1'b1, 1'b0, 1'b0);
    check_cnt("loaduse.StallCount", StallCount, 16'd0);
    tick();
    clear_inputs();
    #1;
    check_ctl("loaduse_release", 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("loaduse_release.StallCount", StallCount, 16'd1);

    // ---------------- no false stalls (no edge taken) ----------------
    IDEXMemRead = 1'b1; IDEXRt = 5'd0; IFIDRs = 5'd0;
    #1;
    check_ctl("r0_no_stall", 1'b1, 1'b0, 1'b0, 1'b0);
    IDEXRt = 5'd7; IFIDRt = 5'd7; IFIDRs = 5'd3; IFIDUseRt = 1'b0;
    #1;
    check_ctl("rt_unused_no_stall", 1'b1, 1'b0, 1'b0, 1'b0);
    IFIDUseRt = 1'b1;
    #1;
    check_ctl("rt_used_stall", 1'b0, 1'b1, 1'b0, 1'b0);
    clear_inputs();
    IFIDBranch = 1'b1; IDEXRegWrite = 1'b1; IDEXRd = 5'd0;
    BranchTaken = 1'b1;
    #1;
    check_ctl("br_rd0_no_stall", 1'b1, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    Jump = 1'b1;
    #1;
    check_ctl("jump_flush", 1'b1, 1'b0, 1'b1, 1'b0);
    clear_inputs();
    #1;
    check_cnt("no_stall.StallCount", StallCount, 16'd1);

    // ---------------- branch after load ----------------
    // Cycle A: lw $8 in EX, beq $8,$9 in ID (taken).
    IDEXMemRead = 1'b1; IDEXRt = 5'd8; IDEXRegWrite = 1'b1; IDEXRd = 5'd8;
    IFIDBranch = 1'b1; IFIDRs = 5'd8; IFIDRt = 5'd9; IFIDUseRt = 1'b1;
    BranchTaken = 1'b1;
    #1;
    check_ctl("br_ex", 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    // Cycle B: lw in MEM, bubble in EX, beq still in ID.
    IDEXMemRead = 1'b0; IDEXRt = 5'd0; IDEXRegWrite = 1'b0; IDEXRd = 5'd0;
    EXMEMMemRead = 1'b1; EXMEMRd = 5'd8;
    #1;
    check_ctl("br_mem", 1'b0, 1'b1, 1'b0, 1'b0);
    check_cnt("br_mem.StallCount", StallCount, 16'd2);
    tick();
    // Cycle C: operand now forwardable, taken branch flushes IF/ID.
    EXMEMMemRead = 1'b0; EXMEMRd = 5'd0;
    #1;
    check_ctl("br_resolve", 1'b1, 1'b0, 1'b1, 1'b0);
    check_cnt("br_resolve.StallCount", StallCount, 16'd3);
    tick();
    clear_inputs();

    // ---------------- mul/div, MULDIV_CYCLES=4 ----------------
    IDEXMulDiv = 1'b1;
    #1;
    check_ctl("md_c0", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    IDEXMemRead = 1'b1; IDEXRt = 5'd5; IFIDRs = 5'd5;
    Jump = 1'b1;
    #1;
    check_ctl("md_c1_loaduse", 1'b0, 1'b0, 1'b0, 1'b1);
    check_cnt("md_c1.StallCount", StallCount, 16'd4);
    tick();
    IDEXMemRead = 1'b0; IDEXRt = 5'd0; IFIDRs = 5'd0; Jump = 1'b0;
    #1;
    check_ctl("md_c2", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_ctl("md_c3", 1'b0, 1'b0, 1'b0, 1'b1);
    check_cnt("md_c3.StallCount", StallCount, 16'd6);
    tick();
    check_ctl("md_c4_release", 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("md_c4.StallCount", StallCount, 16'd7);
    tick();
    // IDEXMulDiv still high: a fresh sequence starts in cycle 5.
    check_ctl("md_c5_fresh", 1'b0, 1'b0, 1'b0, 1'b1);
    check_cnt("md_c5.StallCount", StallCount, 16'd7);
    tick();
    IDEXMulDiv = 1'b0;
    #1;
    check_ctl("md_c6", 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    // cnt is now 2; reset while BUSY.
    check_bit("md_c7.EXHold", EXHold, 1'b1);
    check_cnt("md_c7.StallCount", StallCount, 16'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_ctl("rst_mid_busy", 1'b1, 1'b0, 1'b0, 1'b0);
    check_cnt("rst_mid_busy.StallCount", StallCount, 16'd0);
    tick();
    check_ctl("rst_mid_busy_next", 1'b1, 1'b0, 1'b0, 1'b0);

    // ---------------- saturation ----------------
    IDEXMemRead = 1'b1; IDEXRt = 5'd5; IFIDRs = 5'd5;
    repeat (65534) tick();
    check_cnt("sat.pre", StallCount, 16'hFFFE);
    tick();
    check_cnt("sat.reach", StallCount, 16'hFFFF);
    repeat (5) tick();
    check_cnt("sat.hold", StallCount, 16'hFFFF);
    check_ctl("sat.ctl", 1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline stall/flush controller for the 5-stage MIPS core; the stalling counterpart of the forwarding unit. Forwarding resolves hazards by bypassing values into EX. This block handles the cases bypassing cannot cover: load-use, ID-stage branch operand dependencies, and multi-cycle mul/div occupancy of EX. It drives the PC, IF/ID and ID/EX write, bubble and flush controls, and keeps a saturating stall-cycle counter.

## Interface
- MULDIV_CYCLES, 4: cycles a mul/div holds EX; legal range 1..255.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- IDEXMemRead  in  1  instruction in EX is a load.
- IDEXRt  in  5  load destination in EX.
- IDEXRegWrite  in  1  instruction in EX writes a register.
- IDEXRd  in  5  resolved destination of the instruction in EX.
- EXMEMMemRead  in  1  instruction in MEM is a load.
- EXMEMRd  in  5  destination of the instruction in MEM.
- IFIDRs, IFIDRt  in  5 each  source registers of the instruction in ID.
- IFIDUseRt  in  1  ID instruction reads Rt.
- IFIDBranch  in  1  ID instruction is a conditional branch, compared in ID.
- BranchTaken  in  1  ID comparator result.
- Jump  in  1  ID instruction is a jump.
- IDEXMulDiv  in  1  instruction in EX is mul/div.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID update enable.
- IDEXBubble  out  1  zero the control fields written into ID/EX.
- IFIDFlush  out  1  replace the IF/ID contents with a nop.
- EXHold  out  1  freeze ID/EX and the mul/div unit; insert a bubble into EX/MEM.
- StallCount  out  16  saturating count of cycles with PCWrite=0.

## Operation
- Hold the FSM state (IDLE, BUSY) and an 8-bit counter cnt. Decode all outputs combinationally from the inputs and the current state.
- MulDivHold = (state==IDLE && IDEXMulDiv) || (state==BUSY && cnt!=0).
- LoadUse = IDEXMemRead && IDEXRt!=0 && (IDEXRt==IFIDRs || (IFIDUseRt && IDEXRt==IFIDRt)).
- BrEX = IFIDBranch && IDEXRegWrite && IDEXRd!=0 && (IDEXRd==IFIDRs || IDEXRd==IFIDRt).
- BrMEM = IFIDBranch && EXMEMMemRead && EXMEMRd!=0 && (EXMEMRd==IFIDRs || EXMEMRd==IFIDRt).
- DataStall = !MulDivHold && (LoadUse || BrEX || BrMEM).
- Output equations:
  - EXHold = MulDivHold.
  - PCWrite = IFIDWrite = !(MulDivHold || DataStall).
  - IDEXBubble = DataStall.
  - IFIDFlush = !MulDivHold && !DataStall && ((IFIDBranch && BranchTaken) || Jump).
- Priority: MulDivHold > DataStall > flush.
  - During MulDivHold, ID/EX is held rather than bubbled.
  - During any stall, BranchTaken and Jump are ignored. They are re-evaluated when the stall releases.
- FSM:
  - IDLE: if IDEXMulDiv, then state to BUSY and cnt to MULDIV_CYCLES-1.
  - BUSY: if cnt!=0, decrement cnt. If cnt==0, the hold is released this cycle and state returns to IDLE.
- StallCount increments by 1 on each edge where PCWrite==0. It saturates at 16'hFFFF.

## Timing
- Reset values: state=IDLE, cnt=0, StallCount=0. With all inputs 0, outputs are PCWrite=1, IFIDWrite=1, IDEXBubble=0, IFIDFlush=0, EXHold=0.
- rst takes effect at the edge where it is sampled high. This includes a reset mid-BUSY, where the next cycle is IDLE with cnt=0.
- Stall and flush outputs have zero latency: they are valid in the same cycle as the inputs.
- Mul/div entering EX at cycle T0:
  - EXHold is high for exactly MULDIV_CYCLES cycles, T0..T(M-1).
  - EXHold is low at T(M), where the op advances and state returns to IDLE.
  - A new IDEXMulDiv at T(M+1) starts a fresh sequence.
  - With MULDIV_CYCLES=1, the hold lasts one cycle and BUSY is visited once with cnt=0.
- Load-use: one bubble cycle. The dependent instruction re-decodes the next cycle, and forwarding supplies the value.
- Branch that depends on a load: two stall cycles, BrEX then BrMEM.
- Register 0 never causes a stall.

## Test plan
- Load-use: IDEXMemRead=1, IDEXRt=5, IFIDRs=5 → PCWrite=0, IFIDWrite=0, IDEXBubble=1 for one cycle; StallCount goes 0→1.
- No false stall: IDEXRt=0=IFIDRs, or IFIDUseRt=0 with IDEXRt=IFIDRt=7 → PCWrite=1, IDEXBubble=0.
- Branch after load: lw $8 in EX, then beq $8 in ID → stall from BrEX, then stall from BrMEM. IFIDFlush=0 during both cycles. With BranchTaken=1, IFIDFlush=1 on the third cycle.
- Mul/div with MULDIV_CYCLES=4: IDEXMulDiv held high → EXHold=1 for cycles 0–3 and 0 in cycle 4. A simultaneous LoadUse in cycle 1 leaves IDEXBubble=0. StallCount reaches 4.
- Reset mid-BUSY (cnt=2) with IDEXMulDiv low → the next cycle shows EXHold=0, PCWrite=1, StallCount=0.
- Saturation: force more than 65535 stall cycles → StallCount holds at 16'hFFFF.
